rv_fetch: RTL and testbench
===========================

# rv_fetch

Instruction fetch stage of the uRV core. Maintains the program counter, issues single-outstanding reads to instruction memory, and presents the fetched word with its PC (`f_ir_o`, `f_pc_o`, `f_valid_o`) to the predecode stage, which consumes the `f_ir`/`f_pc` pair. It honours back-pressure from decode through a one-entry holding buffer and redirects on taken branches/jumps from execute, discarding any in-flight stale response.

## Interface
- `BOOT_ADDR`, 32'h0000_0000, PC value loaded on reset.

- `clk_i` in 1: core clock; everything is sampled on the rising edge.
- `rst_n_i` in 1: reset, asynchronous assert, active-low. Release is synchronous to `clk_i`.
- `im_addr_o` out 32: instruction memory word address (byte address; bits [1:0] = 0).
- `im_rd_o` out 1: read strobe, one-cycle pulse per request.
- `im_data_i` in 32: read data, valid when `im_valid_i` = 1.
- `im_valid_i` in 1: read response, in order, at least 1 cycle after `im_rd_o`.
- `f_stall_i` in 1: decode cannot accept; hold the output.
- `x_bra_i` in 1: redirect request from execute.
- `x_pc_bra_i` in 32: redirect target; bits [1:0] ignored and forced to 0.
- `f_ir_o` out 32: fetched instruction.
- `f_pc_o` out 32: PC of `f_ir_o`.
- `f_valid_o` out 1: `f_ir_o`/`f_pc_o` hold a valid instruction.

## Operation
- Registers: `pc` (next fetch address), output register (`f_ir_o`, `f_pc_o`, `f_valid_o`), holding buffer (`hb_ir`, `hb_pc`), `drop` flag, and a state register.
- Reset values: `pc` = `BOOT_ADDR`; `f_ir_o` = 32'h0000_0013 (NOP); `f_pc_o` = `BOOT_ADDR`; `f_valid_o` = 0; `im_rd_o` = 0; `im_addr_o` = `BOOT_ADDR`; `drop` = 0; state = IDLE.
- **Output consumption:** the output is consumed at an edge where `f_valid_o` = 1 and `f_stall_i` = 0. After consumption, `f_valid_o` falls unless new data loads in the same edge.
- **States:**
  - IDLE: `im_rd_o` = 0. Goes to REQ next cycle.
  - REQ: `im_rd_o` = 1, `im_addr_o` = `pc`. Goes to WAIT.
  - WAIT: `im_rd_o` = 0, waiting for `im_valid_i`.
    - If `drop` = 1: discard the data, clear `drop`, go to REQ.
    - Else, if the output is empty or consumed this edge: load `f_ir_o` = `im_data_i`, `f_pc_o` = `pc`, `f_valid_o` = 1; `pc` += 4; go to REQ.
    - Else (output held by stall): load `hb` with `im_data_i`/`pc`; `pc` += 4; go to HOLD.
  - HOLD: `im_rd_o` = 0. When `f_stall_i` = 0, move `hb` to the output (`f_valid_o` stays 1) and go to REQ.
- **Redirect** (`x_bra_i` = 1) overrides everything else in the same edge:
  - `pc` = {`x_pc_bra_i`[31:2], 2'b00}; `f_valid_o` = 0; `hb` is invalidated.
  - From REQ, or from WAIT with `im_valid_i` = 0: a response is still outstanding, so set `drop` = 1 and go to WAIT.
  - From WAIT with `im_valid_i` = 1: discard the data, `drop` = 0, go to REQ.
  - From IDLE or HOLD: go to REQ.
- **PC arithmetic:** 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- `im_valid_i` outside WAIT is ignored; this is a protocol violation by memory.
- **Reset mid-operation:** all state returns to reset values immediately. A response arriving after reset release is ignored unless the state is WAIT, which is reached only after a new REQ.

## Timing
- With 1-cycle memory: REQ at cycle n, `im_valid_i` at n+1, `f_valid_o` high from n+2, next REQ at n+2. Steady-state throughput is one instruction per 2 cycles.
- With L-cycle memory latency, the period is L+1 cycles.
- Redirect to first-valid-output at target: 3 cycles with 1-cycle memory (REQ n+1, data n+2, valid n+3 after redirect edge n). Add 1 cycle if a stale response must still drain.
- No combinational path from inputs to outputs. All outputs are registered except `im_rd_o`/`im_addr_o`, which decode the state and `pc` registers only.

## Test plan
- **Reset/boot:** `BOOT_ADDR` = 32'h100, 1-cycle memory returning addr^32'hA5A5_0000 -> first `im_rd_o` with `im_addr_o` = 32'h100 on the 2nd cycle after release. `f_valid_o` pulses with (`f_ir_o`, `f_pc_o`) = (32'hA5A5_0100, 32'h100), then (32'hA5A5_0104, 32'h104), …, one every 2 cycles.
- **Stall with holding:** hold `f_stall_i` = 1 for 5 cycles while `f_pc_o` = 32'h104 -> output frozen, one request for 32'h108 issued and buffered, no further `im_rd_o`. On release, 32'h108 appears on the next edge, then a REQ for 32'h10C.
- **Redirect while waiting:** 3-cycle memory, `x_bra_i` with `x_pc_bra_i` = 32'h2002 during WAIT -> the stale response is dropped (never shown on `f_ir_o`), next `im_addr_o` = 32'h2000, and `f_pc_o` = 32'h2000 is the first valid output.
- **Redirect coincident with `im_valid_i`:** data is discarded and REQ for the target issues on the next cycle. `f_valid_o` = 0 until target data arrives.
- **Redirect during HOLD:** buffered instruction and output are both invalidated; fetch restarts at the target.
- **Wrap and reset mid-flight:** `pc` = 32'hFFFF_FFFC -> next fetch 32'h0. Asserting `rst_n_i` low during WAIT forces `f_valid_o` = 0 and `im_rd_o` = 0 immediately; the late response is ignored and the restart fetch comes from `BOOT_ADDR`.

Source files
------------

// File: rtl/rv_fetch.sv
// Instruction fetch stage: keeps the PC, issues one outstanding instruction-memory
// read at a time and feeds decode through an output register plus a one-entry holding buffer.
module rv_fetch #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic [31:0] im_addr_o,
  output logic        im_rd_o,
  input  logic [31:0] im_data_i,
  input  logic        im_valid_i,
  input  logic        f_stall_i,
  input  logic        x_bra_i,
  input  logic [31:0] x_pc_bra_i,
  output logic [31:0] f_ir_o,
  output logic [31:0] f_pc_o,
  output logic        f_valid_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fIr_q, fIr_d;
  logic [31:0] fPc_q, fPc_d;
  logic        fValid_q, fValid_d;
  logic [31:0] hbIr_q, hbIr_d;
  logic [31:0] hbPc_q, hbPc_d;
  logic        drop_q, drop_d;

  logic [31:0] pcTarget;
  logic [31:0] pcInc;
  logic        outFree;

  assign pcTarget = {x_pc_bra_i[31:2], 2'b00};
  assign pcInc    = pc_q + 32'd4;
  assign outFree  = !fValid_q || !f_stall_i;

  // Next-state logic; a redirect beats every other event in the same edge.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    fIr_d    = fIr_q;
    fPc_d    = fPc_q;
    fValid_d = fValid_q && f_stall_i;
    hbIr_d   = hbIr_q;
    hbPc_d   = hbPc_q;
    drop_d   = drop_q;

    if (x_bra_i) begin
      pc_d     = pcTarget;
      fValid_d = 1'b0;
      case (state_q)
        REQ: begin
          drop_d  = 1'b1;
          state_d = WAIT;
        end
        WAIT: begin
          if (im_valid_i) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            drop_d  = 1'b1;
            state_d = WAIT;
          end
        end
        default: state_d = REQ;
      endcase
    end else begin
      case (state_q)
        IDLE: state_d = REQ;
        REQ:  state_d = WAIT;
        WAIT: begin
          if (im_valid_i) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = REQ;
            end else if (outFree) begin
              fIr_d    = im_data_i;
              fPc_d    = pc_q;
              fValid_d = 1'b1;
              pc_d     = pcInc;
              state_d  = REQ;
            end else begin
              hbIr_d  = im_data_i;
              hbPc_d  = pc_q;
              pc_d    = pcInc;
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (!f_stall_i) begin
            fIr_d    = hbIr_q;
            fPc_d    = hbPc_q;
            fValid_d = 1'b1;
            state_d  = REQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      pc_q     <= BOOT_ADDR;
      fIr_q    <= NOP;
      fPc_q    <= BOOT_ADDR;
      fValid_q <= 1'b0;
      hbIr_q   <= NOP;
      hbPc_q   <= BOOT_ADDR;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      fIr_q    <= fIr_d;
      fPc_q    <= fPc_d;
      fValid_q <= fValid_d;
      hbIr_q   <= hbIr_d;
      hbPc_q   <= hbPc_d;
      drop_q   <= drop_d;
    end
  end

  assign im_rd_o   = (state_q == REQ);
  assign im_addr_o = pc_q;
  assign f_ir_o    = fIr_q;
  assign f_pc_o    = fPc_q;
  assign f_valid_o = fValid_q;

endmodule

// File: tb/tb_rv_fetch.sv
// Directed bench for rv_fetch: a small instruction memory with programmable
// latency answers every read with addr ^ 32'hA5A5_0000.
module tb_rv_fetch;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [31:0] im_addr_o;
  logic        im_rd_o;
  logic [31:0] im_data_i = 32'h0;
  logic        im_valid_i = 1'b0;
  logic        f_stall_i;
  logic        x_bra_i;
  logic [31:0] x_pc_bra_i;
  logic [31:0] f_ir_o;
  logic [31:0] f_pc_o;
  logic        f_valid_o;

  int checks = 0;
  int errors = 0;

  int          memLat = 1;
  logic        memBusy = 1'b0;
  int          memCnt = 0;
  logic [31:0] memAddr = 32'h0;

  rv_fetch #(.BOOT_ADDR(32'h0000_0100)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .im_addr_o  (im_addr_o),
    .im_rd_o    (im_rd_o),
    .im_data_i  (im_data_i),
    .im_valid_i (im_valid_i),
    .f_stall_i  (f_stall_i),
    .x_bra_i    (x_bra_i),
    .x_pc_bra_i (x_pc_bra_i),
    .f_ir_o     (f_ir_o),
    .f_pc_o     (f_pc_o),
    .f_valid_o  (f_valid_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory deliberately ignores the core reset so that late responses still arrive.
  always @(posedge clk_i) begin
    im_valid_i <= 1'b0;
    if (memBusy) begin
      if (memCnt == 1) begin
        im_valid_i <= 1'b1;
        im_data_i  <= memAddr ^ KEY;
        memBusy    <= 1'b0;
      end else begin
        memCnt <= memCnt - 1;
      end
    end
    if (im_rd_o) begin
      if (memLat == 1) begin
        im_valid_i <= 1'b1;
        im_data_i  <= im_addr_o ^ KEY;
      end else begin
        memBusy <= 1'b1;
        memCnt  <= memLat - 1;
        memAddr <= im_addr_o;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n_i    = 1'b0;
    f_stall_i  = 1'b0;
    x_bra_i    = 1'b0;
    x_pc_bra_i = 32'h0;
    memLat     = 1;
    tick(2);
    checks++; if (f_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", f_valid_o); end
    checks++; if (im_rd_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd: got %0b expected 0", im_rd_o); end
    checks++; if (im_addr_o !== 32'h100) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 00000100", im_addr_o); end
    checks++; if (f_ir_o !== 32'h13) begin errors++; $display("[TB] FAIL reset_ir: got %h expected 00000013", f_ir_o); end
    checks++; if (f_pc_o !== 32'h100) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 00000100", f_pc_o); end
    rst_n_i = 1'b1;
    checks++; if (im_rd_o !== 1'b0) begin errors++; $display("[TB] FAIL boot_idle_rd: got %0b expected 0", im_rd_o); end
    tick(1);
    checks++; if (im_rd_o !== 1'b1 || im_addr_o !== 32'h100) begin errors++; $display("[TB] FAIL boot_first_req: got rd=%0b addr=%h expected rd=1 addr=00000100", im_rd_o, im_addr_o); end
    tick(1);
    checks++; if (im_rd_o !== 1'b0 || f_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL boot_wait: got rd=%0b valid=%0b expected 0/0", im_rd_o, f_valid_o); end
    tick(1);
    checks++; if (f_valid_o !== 1'b1 || f_ir_o !== 32'hA5A5_0100 || f_pc_o !== 32'h100) begin errors++; $display("[TB] FAIL boot_out0: got v=%0b ir=%h pc=%h expected 1 a5a50100 00000100", f_valid_o, f_ir_o, f_pc_o); end
    checks++; if (im_rd_o !== 1'b1 || im_addr_o !== 32'h104) begin errors++; $display("[TB] FAIL boot_req1: got rd=%0b addr=%h expected 1 00000104", im_rd_o, im_addr_o); end
    tick(1);
    checks++; if (f_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL boot_gap: got valid=%0b expected 0", f_valid_o); end
    tick(1);
    checks++; if (f_valid_o !== 1'b1 || f_ir_o !== 32'hA5A5_0104 || f_pc_o !== 32'h104) begin errors++; $display("[TB] FAIL boot_out1: got v=%0b ir=%h pc=%h expected 1 a5a50104 00000104", f_valid_o, f_ir_o, f_pc_o); end
    checks++; if (im_rd_o !== 1'b1 || im_addr_o !== 32'h108) begin errors++; $display("[TB] FAIL boot_req2: got rd=%0b addr=%h expected 1 00000108", im_rd_o, im_addr_o); end
  endtask

  task automatic test_stall_hold;
    int          rdCount;
    logic [31:0] rdAddr;
    logic        frozen;
    rdCount = 0;
    rdAddr  = 32'h0;
    frozen  = 1'b1;
    f_stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (im_rd_o) begin
        rdCount++;
        rdAddr = im_addr_o;
      end
      if (f_valid_o !== 1'b1 || f_pc_o !== 32'h104 || f_ir_o !== 32'hA5A5_0104) frozen = 1'b0;
      tick(1);
    end
    checks++; if (frozen !== 1'b1) begin errors++; $display("[TB] FAIL stall_frozen: got frozen=%0b expected 1", frozen); end
    checks++; if (rdCount != 1 || rdAddr !== 32'h108) begin errors++; $display("[TB] FAIL stall_reqs: got count=%0d addr=%h expected 1 00000108", rdCount, rdAddr); end
    checks++; if (im_rd_o !== 1'b0) begin errors++; $display("[TB] FAIL stall_hold_rd: got %0b expected 0", im_rd_o); end
    f_stall_i = 1'b0;
    tick(1);
    checks++; if (f_valid_o !== 1'b1 || f_pc_o !== 32'h108 || f_ir_o !== 32'hA5A5_0108) begin errors++; $display("[TB] FAIL stall_release_out: got v=%0b ir=%h pc=%h expected 1 a5a50108 00000108", f_valid_o, f_ir_o, f_pc_o); end
    checks++; if (im_rd_o !== 1'b1 || im_addr_o !== 32'h10C) begin errors++; $display("[TB] FAIL stall_release_req: got rd=%0b addr=%h expected 1 0000010c", im_rd_o, im_addr_o); end
    tick(2);
    checks++; if (f_valid_o !== 1'b1 || f_pc_o !== 32'h10C) begin errors++; $display("[TB] FAIL stall_next_out: got v=%0b pc=%h expected 1 0000010c", f_valid_o, f_pc_o); end
  endtask

  task automatic test_redirect_wait;
    int          n;
    logic        sawRd;
    logic [31:0] rdAddr;
    logic        stale;
    memLat = 3;
    tick(1);
    checks++; if (im_rd_o !== 1'b0 || f_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rwait_pre: got rd=%0b valid=%0b expected 0/0", im_rd_o, f_valid_o); end
    x_bra_i    = 1'b1;
    x_pc_bra_i = 32'h2002;
    tick(1);
    x_bra_i = 1'b0;
    n = 0; sawRd = 1'b0; rdAddr = 32'h0; stale = 1'b0;
    while (f_valid_o !== 1'b1 && n < 20) begin
      if (im_rd_o && !sawRd) begin
        sawRd  = 1'b1;
        rdAddr = im_addr_o;
      end
      if (f_ir_o === 32'hA5A5_0110) stale = 1'b1;
      tick(1);
      n++;
    end
    checks++; if (f_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL rwait_timeout: got valid=%0b expected 1 within 20 cycles", f_valid_o); end
    checks++; if (n != 6) begin errors++; $display("[TB] FAIL rwait_latency: got %0d cycles expected 6", n); end
    checks++; if (rdAddr !== 32'h2000) begin errors++; $display("[TB] FAIL rwait_req_addr: got %h expected 00002000", rdAddr); end
    checks++; if (stale !== 1'b0) begin errors++; $display("[TB] FAIL rwait_stale_shown: got %0b expected 0", stale); end
    checks++; if (f_pc_o !== 32'h2000 || f_ir_o !== 32'hA5A5_2000) begin errors++; $display("[TB] FAIL rwait_target_out: got ir=%h pc=%h expected a5a52000 00002000", f_ir_o, f_pc_o); end
  endtask

  task automatic test_redirect_coincident;
    memLat = 1;
    tick(1);
    x_bra_i    = 1'b1;
    x_pc_bra_i = 32'h3001;
    tick(1);
    x_bra_i = 1'b0;
    checks++; if (im_rd_o !== 1'b1 || im_addr_o !== 32'h3000) begin errors++; $display("[TB] FAIL rcoin_req: got rd=%0b addr=%h expected 1 00003000", im_rd_o, im_addr_o); end
    checks++; if (f_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rcoin_valid0: got %0b expected 0", f_valid_o); end
    tick(1);
    checks++; if (f_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rcoin_valid1: got %0b expected 0", f_valid_o); end
    tick(1);
    checks++; if (f_valid_o !== 1'b1 || f_pc_o !== 32'h3000 || f_ir_o !== 32'hA5A5_3000) begin errors++; $display("[TB] FAIL rcoin_out: got v=%0b ir=%h pc=%h expected 1 a5a53000 00003000", f_valid_o, f_ir_o, f_pc_o); end
  endtask

  task automatic test_redirect_hold;
    f_stall_i = 1'b1;
    tick(2);
    checks++; if (im_rd_o !== 1'b0 || f_valid_o !== 1'b1 || f_pc_o !== 32'h3000) begin errors++; $display("[TB] FAIL rhold_pre: got rd=%0b v=%0b pc=%h expected 0 1 00003000", im_rd_o, f_valid_o, f_pc_o); end
    x_bra_i    = 1'b1;
    x_pc_bra_i = 32'h4000;
    tick(1);
    x_bra_i   = 1'b0;
    f_stall_i = 1'b0;
    checks++; if (f_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rhold_flush: got valid=%0b expected 0", f_valid_o); end
    checks++; if (im_rd_o !== 1'b1 || im_addr_o !== 32'h4000) begin errors++; $display("[TB] FAIL rhold_req: got rd=%0b addr=%h expected 1 00004000", im_rd_o, im_addr_o); end
    tick(1);
    checks++; if (f_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rhold_no_hb: got valid=%0b pc=%h expected valid 0", f_valid_o, f_pc_o); end
    tick(1);
    checks++; if (f_valid_o !== 1'b1 || f_pc_o !== 32'h4000 || f_ir_o !== 32'hA5A5_4000) begin errors++; $display("[TB] FAIL rhold_out: got v=%0b ir=%h pc=%h expected 1 a5a54000 00004000", f_valid_o, f_ir_o, f_pc_o); end
  endtask

  task automatic test_wrap;
    x_bra_i    = 1'b1;
    x_pc_bra_i = 32'hFFFF_FFFF;
    tick(1);
    x_bra_i = 1'b0;
    checks++; if (f_valid_o !== 1'b0 || im_rd_o !== 1'b0) begin errors++; $display("[TB] FAIL wrap_drain: got v=%0b rd=%0b expected 0 0", f_valid_o, im_rd_o); end
    tick(1);
    checks++; if (im_rd_o !== 1'b1 || im_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_req_top: got rd=%0b addr=%h expected 1 fffffffc", im_rd_o, im_addr_o); end
    tick(2);
    checks++; if (f_valid_o !== 1'b1 || f_pc_o !== 32'hFFFF_FFFC || f_ir_o !== 32'h5A5A_FFFC) begin errors++; $display("[TB] FAIL wrap_out_top: got v=%0b ir=%h pc=%h expected 1 5a5afffc fffffffc", f_valid_o, f_ir_o, f_pc_o); end
    checks++; if (im_rd_o !== 1'b1 || im_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL wrap_req_zero: got rd=%0b addr=%h expected 1 00000000", im_rd_o, im_addr_o); end
    tick(2);
    checks++; if (f_valid_o !== 1'b1 || f_pc_o !== 32'h0 || f_ir_o !== 32'hA5A5_0000) begin errors++; $display("[TB] FAIL wrap_out_zero: got v=%0b ir=%h pc=%h expected 1 a5a50000 00000000", f_valid_o, f_ir_o, f_pc_o); end
  endtask

  task automatic test_reset_midflight;
    f_stall_i = 1'b1;
    memLat    = 3;
    tick(1);
    checks++; if (f_valid_o !== 1'b1 || im_rd_o !== 1'b0) begin errors++; $display("[TB] FAIL rmid_pre: got v=%0b rd=%0b expected 1 0", f_valid_o, im_rd_o); end
    #2;
    rst_n_i   = 1'b0;
    f_stall_i = 1'b0;
    #1;
    checks++; if (f_valid_o !== 1'b0 || im_rd_o !== 1'b0) begin errors++; $display("[TB] FAIL rmid_async: got v=%0b rd=%0b expected 0 0", f_valid_o, im_rd_o); end
    checks++; if (im_addr_o !== 32'h100 || f_ir_o !== 32'h13) begin errors++; $display("[TB] FAIL rmid_values: got addr=%h ir=%h expected 00000100 00000013", im_addr_o, f_ir_o); end
    tick(1);
    rst_n_i = 1'b1;
    tick(1);
    memLat = 1;
    checks++; if (im_rd_o !== 1'b1 || im_addr_o !== 32'h100 || f_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rmid_restart_req: got rd=%0b addr=%h v=%0b expected 1 00000100 0", im_rd_o, im_addr_o, f_valid_o); end
    tick(1);
    checks++; if (f_valid_o !== 1'b0 || im_rd_o !== 1'b0) begin errors++; $display("[TB] FAIL rmid_late_ignored: got v=%0b rd=%0b ir=%h expected 0 0", f_valid_o, im_rd_o, f_ir_o); end
    tick(1);
    checks++; if (f_valid_o !== 1'b1 || f_pc_o !== 32'h100 || f_ir_o !== 32'hA5A5_0100) begin errors++; $display("[TB] FAIL rmid_boot_out: got v=%0b ir=%h pc=%h expected 1 a5a50100 00000100", f_valid_o, f_ir_o, f_pc_o); end
  endtask

  initial begin
    test_reset();
    test_stall_hold();
    test_redirect_wait();
    test_redirect_coincident();
    test_redirect_hold();
    test_wrap();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
